// File: rtl/nic_pkt_assembler_if.sv
// Bundle between the core-side flit injector, the packet assembler and the output buffer.
// master = core/buffer side, slave = assembler side.
interface nic_pkt_assembler_if #(
    parameter int FLIT_WIDTH           = 16,
    parameter int MAX_PACKET_LENGHT    = 5,
    parameter int N_BITS_VNET_ID       = 1,
    parameter int N_BITS_PACKET_LENGHT = $clog2(MAX_PACKET_LENGHT) + 1
);
    logic [FLIT_WIDTH-1:0]                   flit_i;
    logic                                    flit_valid_i;
    logic                                    flit_last_i;
    logic [N_BITS_VNET_ID-1:0]               vnet_id_i;
    logic                                    flit_ready_o;
    logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_o;
    logic [N_BITS_VNET_ID-1:0]               vnet_id_o;
    logic                                    is_valid_o;
    logic                                    free_slot_i;
    logic [N_BITS_PACKET_LENGHT-1:0]         pkt_length_o;
    logic                                    error_o;

    modport master (
        output flit_i, flit_valid_i, flit_last_i, vnet_id_i, free_slot_i,
        input  flit_ready_o, pkt_o, vnet_id_o, is_valid_o, pkt_length_o, error_o
    );

    modport slave (
        input  flit_i, flit_valid_i, flit_last_i, vnet_id_i, free_slot_i,
        output flit_ready_o, pkt_o, vnet_id_o, is_valid_o, pkt_length_o, error_o
    );
endinterface

// File: rtl/nic_pkt_assembler.sv
// Collects one packet flit-by-flit into a zero-padded vector and hands it to the
// NIC output buffer with a single-cycle is_valid pulse once a slot is free.
module nic_pkt_assembler #(
    parameter int FLIT_WIDTH           = 16,
    parameter int MAX_PACKET_LENGHT    = 5,
    parameter int N_OF_VN              = 2,
    parameter int N_BITS_VNET_ID       = (N_OF_VN > 1) ? $clog2(N_OF_VN) : 1,
    parameter int N_BITS_PACKET_LENGHT = $clog2(MAX_PACKET_LENGHT) + 1
) (
    input  logic               clk,
    input  logic               rst,
    nic_pkt_assembler_if.slave bus
);
    localparam int PKT_W = MAX_PACKET_LENGHT * FLIT_WIDTH;
    localparam int LEN_W = N_BITS_PACKET_LENGHT;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        WAIT,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [PKT_W-1:0]          pkt_p1;
    logic [LEN_W-1:0]          cnt_p1;
    logic [N_BITS_VNET_ID-1:0] vnet_p1;
    logic                      err_p1;

    logic ready;
    logic accept;
    logic store_en;
    logic latch_vnet;
    logic clear_en;
    logic err_set;

    assign accept = bus.flit_valid_i & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        store_en   = 1'b0;
        latch_vnet = 1'b0;
        clear_en   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    store_en   = 1'b1;
                    latch_vnet = 1'b1;
                    state_next = bus.flit_last_i ? WAIT : COLLECT;
                end
            end
            COLLECT: begin
                ready = 1'b1;
                if (accept) begin
                    store_en = 1'b1;
                    if (bus.flit_last_i) begin
                        state_next = WAIT;
                    end else if (cnt_p1 == LEN_W'(MAX_PACKET_LENGHT - 1)) begin
                        // Buffer full but the packet continues: flag once, swallow the tail.
                        err_set    = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                ready = 1'b1;
                if (accept && bus.flit_last_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.free_slot_i) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                clear_en   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Packet storage stage: slot selected by the running flit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_p1  <= '0;
            cnt_p1  <= '0;
            vnet_p1 <= '0;
            err_p1  <= 1'b0;
        end else begin
            err_p1 <= err_set;
            if (clear_en) begin
                pkt_p1 <= '0;
                cnt_p1 <= '0;
            end else if (store_en) begin
                for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
                    if (cnt_p1 == LEN_W'(k)) begin
                        pkt_p1[k*FLIT_WIDTH +: FLIT_WIDTH] <= bus.flit_i;
                    end
                end
                cnt_p1 <= cnt_p1 + LEN_W'(1);
            end
            if (latch_vnet) begin
                vnet_p1 <= bus.vnet_id_i;
            end
        end
    end

    assign bus.flit_ready_o = ready;
    assign bus.pkt_o        = pkt_p1;
    assign bus.vnet_id_o    = vnet_p1;
    assign bus.pkt_length_o = cnt_p1;
    assign bus.error_o      = err_p1;
    assign bus.is_valid_o   = (state == EMIT);

endmodule
